// File: rtl/lsu_mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// lsu_mem_stage_pkg
// Shared definitions for the load/store unit: datapath and bus widths, the
// funct3-style LSU op codes and the 2-bit FSM state encoding.
// ----------------------------------------------------------------------------
package lsu_mem_stage_pkg;

  localparam int XLEN      = 64;
  localparam int BUS_BYTES = 8;
  localparam int OFF_W     = $clog2(BUS_BYTES);

  // Access size lives in op[1:0]; op[2] selects zero-extension for loads.
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_stage_align.sv
// ----------------------------------------------------------------------------
// lsu_mem_stage_align
// Purely combinational byte-lane logic for the LSU.
//   op_i         : LSU op code (size in [1:0], unsigned-load flag in [2])
//   off_i        : byte offset of the access within the bus word
//   wdata_i      : right-aligned store data
//   rdata_i      : aligned bus read data
//   wmask_o      : byte-lane mask of the access
//   lane_wdata_o : store data shifted into its byte lanes
//   load_data_o  : extracted and sign/zero-extended load data
//   misalign_o   : access crosses its natural alignment
// ----------------------------------------------------------------------------
module lsu_mem_stage_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [2:0]           op_i,
  input  logic [OFF_W-1:0]     off_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic [XLEN-1:0]      rdata_i,
  output logic [BUS_BYTES-1:0] wmask_o,
  output logic [XLEN-1:0]      lane_wdata_o,
  output logic [XLEN-1:0]      load_data_o,
  output logic                 misalign_o
);

  logic [OFF_W+2:0]     shamt;
  logic [XLEN-1:0]      raw;
  logic [BUS_BYTES-1:0] base_mask;
  logic                 is_unsigned;
  logic                 sext;

  assign shamt        = {off_i, 3'b000};
  assign raw          = rdata_i >> shamt;
  assign lane_wdata_o = wdata_i << shamt;
  assign wmask_o      = base_mask << off_i;

  // Op 111 has size bits 11 and so falls through to the full-width case,
  // where extension is irrelevant.
  assign is_unsigned = (op_i == LSU_BU) || (op_i == LSU_HU) || (op_i == LSU_WU);

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a value held, which would infer a latch.
  always_comb begin
    base_mask   = '1;
    misalign_o  = 1'b0;
    sext        = 1'b0;
    load_data_o = raw;
    case (op_i[1:0])
      LSU_B[1:0]: begin
        base_mask   = 8'h01;
        sext        = raw[7] & ~is_unsigned;
        load_data_o = {{(XLEN-8){sext}}, raw[7:0]};
      end
      LSU_H[1:0]: begin
        base_mask   = 8'h03;
        misalign_o  = off_i[0];
        sext        = raw[15] & ~is_unsigned;
        load_data_o = {{(XLEN-16){sext}}, raw[15:0]};
      end
      LSU_W[1:0]: begin
        base_mask   = 8'h0F;
        misalign_o  = (off_i[1:0] != 2'b00);
        sext        = raw[31] & ~is_unsigned;
        load_data_o = {{(XLEN-32){sext}}, raw[31:0]};
      end
      LSU_D[1:0]: begin
        base_mask   = 8'hFF;
        misalign_o  = (off_i != '0);
        load_data_o = raw;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// lsu_mem_stage
// Load/store unit downstream of the ALU. Accepts one memory op at a time,
// issues it on a valid/ready request bus, waits for the response and returns
// extended load data (or a store acknowledge) to writeback as a 1-cycle pulse.
//   clk, rst_n         : clock, asynchronous active-low reset
//   ex_*_i / ex_ready_o: op handshake from execute (ready only when idle)
//   mem_req_*_o        : registered bus request (addr aligned to the bus word)
//   mem_req_ready_i    : bus accepts the request
//   mem_resp_*_i       : read data / write ack, only observed while waiting
//   wb_*_o             : result pulse, data and misalignment flag
// ----------------------------------------------------------------------------
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic                 ex_is_store_i,
  input  logic [2:0]           ex_lsu_op_i,
  input  logic [XLEN-1:0]      ex_addr_i,
  input  logic [XLEN-1:0]      ex_wdata_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [XLEN-1:0]      mem_req_addr_o,
  output logic                 mem_req_we_o,
  output logic [XLEN-1:0]      mem_req_wdata_o,
  output logic [BUS_BYTES-1:0] mem_req_wmask_o,
  input  logic                 mem_resp_valid_i,
  input  logic [XLEN-1:0]      mem_resp_rdata_i,
  output logic                 wb_valid_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic                 wb_misalign_o
);

  lsu_state_e           state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 is_store_q, is_store_d;
  logic [OFF_W-1:0]     off_q, off_d;
  logic                 req_valid_q, req_valid_d;
  logic [XLEN-1:0]      req_addr_q, req_addr_d;
  logic                 req_we_q, req_we_d;
  logic [XLEN-1:0]      req_wdata_q, req_wdata_d;
  logic [BUS_BYTES-1:0] req_wmask_q, req_wmask_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic                 wb_misalign_q, wb_misalign_d;

  logic [2:0]           align_op;
  logic [OFF_W-1:0]     align_off;
  logic [BUS_BYTES-1:0] align_wmask;
  logic [XLEN-1:0]      align_wdata;
  logic [XLEN-1:0]      align_load;
  logic                 align_misalign;

  // One alignment unit serves both phases: in IDLE it sees the incoming op
  // (lane/mask/misalign for the request); afterwards it sees the latched op
  // so the response can be extracted in WAIT.
  assign align_op  = (state_q == ST_IDLE) ? ex_lsu_op_i : op_q;
  assign align_off = (state_q == ST_IDLE) ? ex_addr_i[OFF_W-1:0] : off_q;

  lsu_mem_stage_align u_align (
    .op_i         (align_op),
    .off_i        (align_off),
    .wdata_i      (ex_wdata_i),
    .rdata_i      (mem_resp_rdata_i),
    .wmask_o      (align_wmask),
    .lane_wdata_o (align_wdata),
    .load_data_o  (align_load),
    .misalign_o   (align_misalign)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    is_store_d    = is_store_q;
    off_d         = off_q;
    req_valid_d   = req_valid_q;
    req_addr_d    = req_addr_q;
    req_we_d      = req_we_q;
    req_wdata_d   = req_wdata_q;
    req_wmask_d   = req_wmask_q;
    wb_valid_d    = wb_valid_q;
    wb_data_d     = wb_data_q;
    wb_misalign_d = wb_misalign_q;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid_i) begin
          op_d       = ex_lsu_op_i;
          is_store_d = ex_is_store_i;
          off_d      = ex_addr_i[OFF_W-1:0];
          if (align_misalign) begin
            // Never reaches the bus: report straight from DONE.
            wb_valid_d    = 1'b1;
            wb_misalign_d = 1'b1;
            wb_data_d     = '0;
            state_d       = ST_DONE;
          end else begin
            req_valid_d = 1'b1;
            req_addr_d  = {ex_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            req_we_d    = ex_is_store_i;
            req_wdata_d = align_wdata;
            req_wmask_d = align_wmask;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready_i) begin
          req_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid_i) begin
          wb_valid_d = 1'b1;
          wb_data_d  = is_store_q ? '0 : align_load;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        wb_valid_d    = 1'b0;
        wb_data_d     = '0;
        wb_misalign_d = 1'b0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      is_store_q    <= 1'b0;
      off_q         <= '0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      req_we_q      <= 1'b0;
      req_wdata_q   <= '0;
      req_wmask_q   <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      is_store_q    <= is_store_d;
      off_q         <= off_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      req_we_q      <= req_we_d;
      req_wdata_q   <= req_wdata_d;
      req_wmask_q   <= req_wmask_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_misalign_q <= wb_misalign_d;
    end
  end

  assign ex_ready_o      = (state_q == ST_IDLE);
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_req_we_o    = req_we_q;
  assign mem_req_wdata_o = req_wdata_q;
  assign mem_req_wmask_o = req_wmask_q;
  assign wb_valid_o      = wb_valid_q;
  assign wb_data_o       = wb_data_q;
  assign wb_misalign_o   = wb_misalign_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_stage
// Directed and randomized load/store transactions against lsu_mem_stage.
// Expected bus fields and writeback data come from a byte-level model of the
// load/store rules. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic        ex_is_store_i;
  logic [2:0]  ex_lsu_op_i;
  logic [63:0] ex_addr_i;
  logic [63:0] ex_wdata_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_req_addr_o;
  logic        mem_req_we_o;
  logic [63:0] mem_req_wdata_o;
  logic [7:0]  mem_req_wmask_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_resp_rdata_i;
  logic        wb_valid_o;
  logic [63:0] wb_data_o;
  logic        wb_misalign_o;

  int checks = 0;
  int errors = 0;

  lsu_mem_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid_i       (ex_valid_i),
    .ex_ready_o       (ex_ready_o),
    .ex_is_store_i    (ex_is_store_i),
    .ex_lsu_op_i      (ex_lsu_op_i),
    .ex_addr_i        (ex_addr_i),
    .ex_wdata_i       (ex_wdata_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_we_o     (mem_req_we_o),
    .mem_req_wdata_o  (mem_req_wdata_o),
    .mem_req_wmask_o  (mem_req_wmask_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_rdata_i (mem_resp_rdata_i),
    .wb_valid_o       (wb_valid_o),
    .wb_data_o        (wb_data_o),
    .wb_misalign_o    (wb_misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: byte-level view of the access ----
  function automatic int size_bytes(input logic [2:0] op);
    case (op[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] op, input int off,
                                             input logic [63:0] rdata);
    int nb;
    logic [63:0] r;
    nb = size_bytes(op);
    r  = '0;
    for (int i = 0; i < nb; i++) r[i*8 +: 8] = rdata[(off+i)*8 +: 8];
    if (!op[2] && nb < 8 && r[nb*8-1])
      for (int i = nb; i < 8; i++) r[i*8 +: 8] = 8'hFF;
    return r;
  endfunction

  // One transaction starting at a falling edge with the DUT idle; returns at
  // the falling edge after the DONE cycle (DUT idle again).
  task automatic run_op(input logic st, input logic [2:0] op, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input int rdly, input int sdly, output logic [63:0] got);
    int          nb;
    int          off;
    logic        mis;
    logic [63:0] exp_data;
    logic [63:0] exp_addr;
    logic [63:0] exp_lanes;
    logic [63:0] lane_bits;
    logic [7:0]  exp_mask;
    nb        = size_bytes(op);
    off       = int'(addr[2:0]);
    mis       = (off % nb) != 0;
    exp_data  = st ? 64'd0 : model_load(op, off, rdata);
    exp_addr  = {addr[63:3], 3'b000};
    exp_mask  = '0;
    exp_lanes = '0;
    lane_bits = '0;
    if (!mis)
      for (int i = 0; i < nb; i++) begin
        exp_mask[off+i]          = 1'b1;
        exp_lanes[(off+i)*8 +: 8] = wdata[i*8 +: 8];
        lane_bits[(off+i)*8 +: 8] = 8'hFF;
      end
    got = '0;

    check("ex_ready_before_accept", ex_ready_o, 1);
    ex_valid_i    = 1'b1;
    ex_is_store_i = st;
    ex_lsu_op_i   = op;
    ex_addr_i     = addr;
    ex_wdata_i    = wdata;
    @(negedge clk);
    // Scramble the execute inputs: the DUT must work from its latched copy.
    ex_valid_i    = 1'b0;
    ex_is_store_i = ~st;
    ex_lsu_op_i   = ~op;
    ex_addr_i     = {$urandom, $urandom};
    ex_wdata_i    = ~wdata;

    if (mis) begin
      check("mis_wb_valid", wb_valid_o, 1);
      check("mis_flag", wb_misalign_o, 1);
      check("mis_wb_data", wb_data_o, 0);
      check("mis_no_req", mem_req_valid_o, 0);
      got = wb_data_o;
    end else begin
      check("req_valid", mem_req_valid_o, 1);
      check("req_addr", mem_req_addr_o, exp_addr);
      check("req_we", mem_req_we_o, st);
      if (st) begin
        check("req_wmask", mem_req_wmask_o, exp_mask);
        check("req_wdata_lanes", mem_req_wdata_o & lane_bits, exp_lanes);
      end
      for (int i = 0; i < rdly; i++) begin
        @(negedge clk);
        check("stall_req_valid", mem_req_valid_o, 1);
        check("stall_req_addr", mem_req_addr_o, exp_addr);
        check("stall_req_we", mem_req_we_o, st);
        if (st) check("stall_req_wmask", mem_req_wmask_o, exp_mask);
        check("stall_ex_ready", ex_ready_o, 0);
        check("stall_wb_valid", wb_valid_o, 0);
      end
      mem_req_ready_i = 1'b1;
      @(negedge clk);
      mem_req_ready_i = 1'b0;
      check("req_dropped", mem_req_valid_o, 0);
      check("wait_ex_ready", ex_ready_o, 0);
      check("wait_wb_valid", wb_valid_o, 0);
      for (int i = 0; i < sdly; i++) begin
        @(negedge clk);
        check("resp_wait_wb_valid", wb_valid_o, 0);
        check("resp_wait_ex_ready", ex_ready_o, 0);
      end
      mem_resp_valid_i = 1'b1;
      mem_resp_rdata_i = rdata;
      @(negedge clk);
      mem_resp_valid_i = 1'b0;
      mem_resp_rdata_i = {$urandom, $urandom};
      check("wb_valid", wb_valid_o, 1);
      check("wb_data", wb_data_o, exp_data);
      check("wb_misalign", wb_misalign_o, 0);
      check("done_ex_ready", ex_ready_o, 0);
      got = wb_data_o;
    end

    @(negedge clk);
    check("wb_valid_cleared", wb_valid_o, 0);
    check("wb_data_cleared", wb_data_o, 0);
    check("wb_misalign_cleared", wb_misalign_o, 0);
    check("ex_ready_after_done", ex_ready_o, 1);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] addr;
    logic [2:0]  op;
    int          nb;
    int          off;

    rst_n            = 1'b0;
    ex_valid_i       = 1'b0;
    ex_is_store_i    = 1'b0;
    ex_lsu_op_i      = 3'b000;
    ex_addr_i        = '0;
    ex_wdata_i       = '0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_rdata_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ex_ready", ex_ready_o, 1);
    check("rst_req_valid", mem_req_valid_o, 0);
    check("rst_req_addr", mem_req_addr_o, 0);
    check("rst_req_we", mem_req_we_o, 0);
    check("rst_req_wdata", mem_req_wdata_o, 0);
    check("rst_req_wmask", mem_req_wmask_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_wb_misalign", wb_misalign_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // LB sign extension from byte 3
    run_op(1'b0, 3'b000, 64'h0000_0000_8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, got);
    check("lb_const", got, 64'hFFFF_FFFF_FFFF_FF80);
    // LWU / LW of the upper word
    run_op(1'b0, 3'b110, 64'h0000_0000_8000_0004, 64'd0, 64'hDEAD_BEEF_1234_5678, 0, 0, got);
    check("lwu_const", got, 64'h0000_0000_DEAD_BEEF);
    run_op(1'b0, 3'b010, 64'h0000_0000_8000_0004, 64'd0, 64'hDEAD_BEEF_1234_5678, 0, 0, got);
    check("lw_const", got, 64'hFFFF_FFFF_DEAD_BEEF);
    // SH into the top half-word
    run_op(1'b1, 3'b001, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_ABCD, {$urandom, $urandom}, 0, 0, got);
    check("sh_wb_zero", got, 64'd0);
    // Misaligned LD
    run_op(1'b0, 3'b011, 64'h0000_0000_8000_0004, 64'd0, 64'd0, 0, 0, got);
    check("ld_mis_zero", got, 64'd0);
    // Op 111 behaves as D
    run_op(1'b0, 3'b111, 64'h0000_0000_8000_0010, 64'd0, 64'h8123_4567_89AB_CDEF, 0, 0, got);
    check("op111_const", got, 64'h8123_4567_89AB_CDEF);
    // Long stall then a back-to-back store
    run_op(1'b0, 3'b001, 64'h0000_0000_8000_0002, 64'd0, 64'h0000_0000_F00D_0000, 5, 3, got);
    check("lh_stall_const", got, 64'hFFFF_FFFF_FFFF_F00D);
    run_op(1'b1, 3'b000, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_005A, 64'd0, 0, 0, got);

    // Reset while waiting for the response
    ex_valid_i    = 1'b1;
    ex_is_store_i = 1'b0;
    ex_lsu_op_i   = 3'b011;
    ex_addr_i     = 64'h0000_0000_8000_0008;
    @(negedge clk);
    ex_valid_i      = 1'b0;
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ex_ready", ex_ready_o, 1);
    check("midrst_req_valid", mem_req_valid_o, 0);
    check("midrst_req_addr", mem_req_addr_o, 0);
    check("midrst_wb_valid", wb_valid_o, 0);
    @(negedge clk);
    rst_n            = 1'b1;
    mem_resp_valid_i = 1'b1;
    mem_resp_rdata_i = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_resp_wb_valid", wb_valid_o, 0);
      check("late_resp_wb_data", wb_data_o, 0);
      check("late_resp_ex_ready", ex_ready_o, 1);
      check("late_resp_req_valid", mem_req_valid_o, 0);
      @(negedge clk);
    end

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      op   = 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      nb   = size_bytes(op);
      if ($urandom_range(0, 3) != 0) begin
        off        = int'(addr[2:0]);
        off        = off - (off % nb);
        addr[2:0]  = 3'(off);
      end
      run_op(1'($urandom_range(0, 1)), op, addr, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit that sits directly downstream of the ALU.
- Consumes the ALU result as the effective address and the rs2 value as store data.
- Performs one memory transaction at a time over a valid/ready request bus with a separate response channel.
- Returns extracted, sign/zero-extended load data (or a store acknowledge) to writeback as a one-cycle pulse.
- Replaces the combinational DPI load path with a real multi-cycle memory interface.

Parameters:
- XLEN, 64, datapath and address width.
- BUS_BYTES, 8, memory bus width in bytes; the bus address is aligned to this width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage presents a memory op.
- ex_ready  out  1  LSU can accept; equals (state==IDLE).
- ex_is_store  in  1  1=store, 0=load.
- ex_lsu_op  in  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D; bit2 selects unsigned load (100 BU, 101 HU, 110 WU).
- ex_addr  in  XLEN  effective address (ALU result).
- ex_wdata  in  XLEN  store data, right-aligned.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_req_addr  out  XLEN  ex_addr with bits[2:0] cleared.
- mem_req_we  out  1  write enable.
- mem_req_wdata  out  XLEN  store data shifted into its byte lanes.
- mem_req_wmask  out  8  byte-lane write mask.
- mem_resp_valid  in  1  read data or write ack is valid.
- mem_resp_rdata  in  XLEN  aligned 64-bit read data.
- wb_valid  out  1  one-cycle result pulse.
- wb_data  out  XLEN  extended load data; 0 for stores and on error.
- wb_misalign  out  1  address-misaligned flag, qualified by wb_valid.

Behaviour:
- Reset:
  - state=IDLE.
  - mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask, wb_valid, wb_data, wb_misalign all 0.
  - ex_ready reads 1 while in reset.
- Request channels use registered outputs.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - An op is accepted on ex_valid && ex_ready.
  - On accept, latch op, is_store, addr and wdata.
  - If misaligned, go to DONE. Otherwise assert mem_req_valid with the computed addr/we/wdata/wmask, then go to REQ.
  - Misaligned means: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0.
- REQ:
  - mem_req_* are held stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready, drop mem_req_valid and go to WAIT.
- WAIT:
  - On mem_resp_valid, register wb_data and go to DONE.
  - For loads, wb_data = extracted/extended rdata. For stores, wb_data = 0.
  - mem_resp_valid is ignored in every other state.
- DONE:
  - wb_valid=1 for exactly one cycle, then return to IDLE.
  - wb_misalign=1 only for misaligned ops; wb_data=0 in that case.
  - wb_valid, wb_data and wb_misalign clear to 0 on return to IDLE.
- Load extraction:
  - off = addr[2:0]; raw = rdata >> (off*8).
  - B/H/W take raw[7:0], raw[15:0], raw[31:0] respectively.
  - Sign-extend to XLEN when op[2]=0; zero-extend when op[2]=1. D takes raw[63:0].
- Store lanes:
  - wdata is replicated/shifted left by off*8.
  - wmask = base << off, with base 0x01 (B), 0x03 (H), 0x0F (W), 0xFF (D).
  - Stores ignore op[2]; size comes from op[1:0].
- Op 111 is treated as D (load or store).
- Latency, zero-wait bus (ready on first REQ cycle, response on first WAIT cycle):
  - accept at cycle N, wb_valid at N+3.
  - misaligned: wb_valid at N+1.
- The next op is accepted in the cycle after DONE, because ex_ready=1 in IDLE.
- Reset asserted mid-transaction: immediate return to IDLE, request dropped, no wb_valid. A late mem_resp_valid is ignored in IDLE.
- Handshake and response never complete in the same state; the bus guarantees the response arrives at least one cycle after the accepted request.

Decomposition:
- rvseed_defines gains:
  - LSU op codes (LSU_B, LSU_H, LSU_W, LSU_D, LSU_BU, LSU_HU, LSU_WU).
  - The LSU FSM state encoding (2 bits).
  - The BUS_BYTES constant.
- One combinational sub-module, lsu_align:
  - inputs op, off, wdata, rdata.
  - outputs wmask, lane wdata, extended load data, misalign.
- lsu_mem_stage holds the FSM and registers.

Test Plan:
- LB at addr 0x8000_0003, rdata 0x0000_0000_8000_0000 (byte 3 = 0x80), ready and response immediate -> mem_req_addr 0x8000_0000, wb_data 0xFFFF_FFFF_FFFF_FF80, wb_valid at N+3.
- LWU at 0x8000_0004, rdata 0xDEAD_BEEF_1234_5678 -> wb_data 0x0000_0000_DEAD_BEEF; LW with the same stimulus -> 0xFFFF_FFFF_DEAD_BEEF.
- SH at 0x8000_0006, wdata 0xABCD -> mem_req_we=1, wmask 0xC0, mem_req_wdata[63:48]=0xABCD; wb_data 0 after the ack.
- LD at 0x8000_0004 -> no mem_req_valid, wb_valid with wb_misalign=1 and wb_data=0 at N+1.
- mem_req_ready held low 5 cycles, then response delayed 3 cycles -> req fields stable throughout, ex_ready=0 throughout, single wb_valid pulse, a back-to-back second op accepted the cycle after DONE.
- rst_n pulsed low while in WAIT, then mem_resp_valid arrives -> no wb_valid, all outputs 0, ex_ready=1.
